// File: rtl/pulse_sweep_sched.sv
// pulse_sweep_sched
// Sole writer to the pulse generator's 32-bit command FIFO. Runs autonomous
// fine/coarse delay sweeps (set_period, reset_clock, then trains of
// send_pulse words) and round-robin arbitrates a host passthrough channel
// against the sweep engine, with at most one FIFO write per cycle.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for sweep_start; sweep has no pending word
// CFG_PERIOD | offering {8'h02, period}
// CFG_RST    | offering reset_clock (32'h0)
// PULSE      | offering {8'h01, coarse, fine}, reps words per delay step
// ADVANCE    | one cycle, no write: step delay or finish
// DONE       | one-cycle completion pulse on done
module pulse_sweep_sched #(
    parameter int FINE_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_valid,
    input  logic [31:0]      host_data,
    output logic             host_ready,
    input  logic             sweep_start,
    input  logic             sweep_abort,
    input  logic [23:0]      sweep_period,
    input  logic [15:0]      sweep_coarse_start,
    input  logic [7:0]       sweep_fine_start,
    input  logic [7:0]       sweep_step_fine,
    input  logic [CNT_W-1:0] sweep_num_steps,
    input  logic [CNT_W-1:0] sweep_reps,
    input  logic             fifo_full,
    output logic             fifo_wr,
    output logic [31:0]      fifo_wdata,
    output logic             busy,
    output logic             done,
    output logic [7:0]       state_out
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CFG_PERIOD = 3'd1,
        S_CFG_RST    = 3'd2,
        S_PULSE      = 3'd3,
        S_ADVANCE    = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    localparam logic [7:0] CMD_RESET_CLOCK = 8'h00;
    localparam logic [7:0] CMD_SEND_PULSE  = 8'h01;
    localparam logic [7:0] CMD_SET_PERIOD  = 8'h02;
    localparam logic [7:0] FINE_MAX_B      = 8'(FINE_MAX);
    localparam logic [8:0] FINE_MAX_W      = 9'(FINE_MAX);
    localparam logic [8:0] FINE_WRAP_W     = 9'(FINE_MAX + 1);

    state_t           state_q, state_d;
    logic [23:0]      period_q, period_d;
    logic [15:0]      coarse_q, coarse_d;
    logic [7:0]       fine_q, fine_d;
    logic [7:0]       step_q, step_d;
    logic [CNT_W-1:0] num_steps_q, num_steps_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    // 1 when the host received the most recent FIFO write
    logic             last_host_q, last_host_d;

    logic             sweep_req;
    logic [31:0]      sweep_word;
    logic             grant_sweep;
    logic             grant_host;
    logic             wr_any;
    logic             sweep_wr;
    logic [7:0]       fine_start_clamped;
    logic [7:0]       step_clamped;
    logic [8:0]       fine_sum;
    logic [7:0]       fine_stepped;
    logic             fine_carry;
    logic [CNT_W-1:0] step_cnt_inc;
    logic [CNT_W-1:0] reps_last;

    // State and sweep registers; reset abandons any partial sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            period_q    <= '0;
            coarse_q    <= '0;
            fine_q      <= '0;
            step_q      <= '0;
            num_steps_q <= '0;
            reps_q      <= '0;
            rep_cnt_q   <= '0;
            step_cnt_q  <= '0;
            last_host_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            coarse_q    <= coarse_d;
            fine_q      <= fine_d;
            step_q      <= step_d;
            num_steps_q <= num_steps_d;
            reps_q      <= reps_d;
            rep_cnt_q   <= rep_cnt_d;
            step_cnt_q  <= step_cnt_d;
            last_host_q <= last_host_d;
        end
    end

    // Input clamping and delay-step arithmetic
    always_comb begin
        fine_start_clamped = (sweep_fine_start > FINE_MAX_B) ? FINE_MAX_B : sweep_fine_start;
        step_clamped       = (sweep_step_fine > FINE_MAX_B) ? FINE_MAX_B : sweep_step_fine;
        fine_sum           = {1'b0, fine_q} + {1'b0, step_q};
        fine_carry         = (fine_sum > FINE_MAX_W);
        fine_stepped       = fine_carry ? 8'(fine_sum - FINE_WRAP_W) : fine_sum[7:0];
        step_cnt_inc       = step_cnt_q + CNT_W'(1);
        reps_last          = reps_q - CNT_W'(1);
    end

    // Sweep pending word and round-robin arbitration from registered state
    always_comb begin
        sweep_word = 32'h0000_0000;
        sweep_req  = 1'b0;
        case (state_q)
            S_CFG_PERIOD: begin
                sweep_word = {CMD_SET_PERIOD, period_q};
                sweep_req  = 1'b1;
            end
            S_CFG_RST: begin
                sweep_word = {CMD_RESET_CLOCK, 24'h000000};
                sweep_req  = 1'b1;
            end
            S_PULSE: begin
                sweep_word = {CMD_SEND_PULSE, coarse_q, fine_q};
                sweep_req  = 1'b1;
            end
            default: begin
                sweep_word = 32'h0000_0000;
                sweep_req  = 1'b0;
            end
        endcase
        // abort outranks the sweep's own write but leaves the host untouched
        if (sweep_abort) begin
            sweep_req = 1'b0;
        end

        grant_sweep = sweep_req && (!host_valid || last_host_q);
        grant_host  = host_valid && (!sweep_req || !last_host_q);
        wr_any      = (grant_sweep || grant_host) && !fifo_full && !rst;
        sweep_wr    = wr_any && grant_sweep;

        fifo_wr     = wr_any;
        fifo_wdata  = grant_host ? host_data : sweep_word;
        host_ready  = wr_any && grant_host;

        last_host_d = last_host_q;
        if (wr_any) begin
            last_host_d = grant_host;
        end
    end

    // Sweep sequencing: advances only on cycles where its word is written
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        coarse_d    = coarse_q;
        fine_d      = fine_q;
        step_d      = step_q;
        num_steps_d = num_steps_q;
        reps_d      = reps_q;
        rep_cnt_d   = rep_cnt_q;
        step_cnt_d  = step_cnt_q;

        if (state_q != S_IDLE && sweep_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sweep_start && !sweep_abort) begin
                        period_d    = sweep_period;
                        coarse_d    = sweep_coarse_start;
                        fine_d      = fine_start_clamped;
                        step_d      = step_clamped;
                        num_steps_d = sweep_num_steps;
                        reps_d      = sweep_reps;
                        rep_cnt_d   = '0;
                        step_cnt_d  = '0;
                        if (sweep_num_steps == '0 || sweep_reps == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CFG_PERIOD;
                        end
                    end
                end
                S_CFG_PERIOD: begin
                    if (sweep_wr) begin
                        state_d = S_CFG_RST;
                    end
                end
                S_CFG_RST: begin
                    if (sweep_wr) begin
                        state_d = S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (sweep_wr) begin
                        if (rep_cnt_q == reps_last) begin
                            rep_cnt_d = '0;
                            state_d   = S_ADVANCE;
                        end else begin
                            rep_cnt_d = rep_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_ADVANCE: begin
                    if (step_cnt_inc == num_steps_q) begin
                        state_d = S_DONE;
                    end else begin
                        step_cnt_d = step_cnt_inc;
                        fine_d     = fine_stepped;
                        if (fine_carry) begin
                            coarse_d = coarse_q + 16'd1;
                        end
                        state_d = S_PULSE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Status outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE) && !sweep_abort;
        state_out = {5'b00000, state_q};
    end

endmodule
